// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide sequencer (muldiv_seq).
// Holds the FSM state encoding, the funct3 opcode values and the default widths.
package muldiv_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int CNT_W_DEF = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREP,
      ST_RUN,
      ST_FIX,
      ST_DONE
   } state_t;

   localparam logic [2:0] F3_MUL    = 3'd0;
   localparam logic [2:0] F3_MULH   = 3'd1;
   localparam logic [2:0] F3_MULHSU = 3'd2;
   localparam logic [2:0] F3_MULHU  = 3'd3;
   localparam logic [2:0] F3_DIV    = 3'd4;
   localparam logic [2:0] F3_DIVU   = 3'd5;
   localparam logic [2:0] F3_REM    = 3'd6;
   localparam logic [2:0] F3_REMU   = 3'd7;

   function automatic logic is_div_op(input logic [2:0] f3);
      return f3[2];
   endfunction

   function automatic logic is_rem_op(input logic [2:0] f3);
      return f3[2] & f3[1];
   endfunction

endpackage

// File: rtl/muldiv_addsub33.sv
// Combinational (XLEN+1)-bit adder/subtractor shared by the multiply and divide iterations.
// sub=0 gives a+b, sub=1 gives a-b; the result wraps modulo 2**W.
module muldiv_addsub33 #(
   parameter int W = 33
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   output logic [W-1:0] sum
);

   assign sum = sub ? (a - b) : (a + b);

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer for the EX stage: IDLE -> PREP -> RUN -> FIX -> DONE.
// Optional macro MULDIV_FAST_PATH_EN: trivial ops (zero multiply, divide by zero, signed overflow) skip RUN.
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_start,
   input  logic [2:0]      i_funct3,
   input  logic [XLEN-1:0] i_rs1_data,
   input  logic [XLEN-1:0] i_rs2_data,
   input  logic            i_flush,
   output logic            o_busy,
   output logic            o_done,
   output logic [XLEN-1:0] o_result
);

   // Handshake: an op is accepted only when i_start=1 and i_flush=0 in IDLE; o_done is a
   // one-cycle pulse with o_result valid in that cycle, and o_busy covers PREP/RUN/FIX.

   state_t            state, state_n;
   logic [XLEN-1:0]   op_a, op_b, result;
   logic [2:0]        f3;
   logic              neg_res, fast_q;
   logic [2*XLEN-1:0] acc, acc_n, prod_s;
   logic [CNT_W-1:0]  cnt;

   logic              div_op, a_signed, b_signed, a_neg, b_neg, b_zero, prep_neg;
   logic [XLEN-1:0]   mag_a, mag_b, fix_half, fix_val;
   logic [XLEN:0]     add_a, add_b, add_sum, div_shift;
   logic              div_ge, last_iter;
   logic              fast_hit;
   logic [XLEN-1:0]   fast_val;

   // Operand decode; in PREP op_a/op_b still hold the raw latched operands.
   always_comb begin
      div_op   = is_div_op(f3);
      a_signed = (f3 == F3_MULH) | (f3 == F3_MULHSU) | (f3 == F3_DIV) | (f3 == F3_REM);
      b_signed = (f3 == F3_MULH) | (f3 == F3_DIV) | (f3 == F3_REM);
      a_neg    = a_signed & op_a[XLEN-1];
      b_neg    = b_signed & op_b[XLEN-1];
      mag_a    = a_neg ? -op_a : op_a;
      mag_b    = b_neg ? -op_b : op_b;
      b_zero   = (op_b == '0);
      if (is_rem_op(f3)) begin
         prep_neg = a_neg;
      end else if (div_op) begin
         prep_neg = (a_neg ^ b_neg) & ~b_zero;
      end else begin
         prep_neg = a_neg ^ b_neg;
      end
   end

`ifdef MULDIV_FAST_PATH_EN
   logic a_zero, div_ovf;

   always_comb begin
      a_zero   = (op_a == '0);
      div_ovf  = div_op & a_signed & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (op_b == '1);
      fast_hit = 1'b0;
      fast_val = '0;
      if (!div_op) begin
         fast_hit = a_zero | b_zero;
      end else if (b_zero) begin
         fast_hit = 1'b1;
         fast_val = is_rem_op(f3) ? op_a : '1;
      end else if (div_ovf) begin
         fast_hit = 1'b1;
         fast_val = is_rem_op(f3) ? '0 : op_a;
      end
   end
`else
   assign fast_hit = 1'b0;
   assign fast_val = '0;
`endif

   // Multiply: hi += multiplicand when multiplier LSB set, then shift {hi,lo} right.
   // Divide: shift remainder left by one dividend bit and try subtracting the divisor.
   always_comb begin
      div_shift = {acc[2*XLEN-1:XLEN], op_a[XLEN-1]};
      if (div_op) begin
         add_a = div_shift;
         add_b = {1'b0, op_b};
      end else begin
         add_a = {1'b0, acc[2*XLEN-1:XLEN]};
         add_b = op_b[0] ? {1'b0, op_a} : '0;
      end
   end

   muldiv_addsub33 #(.W(XLEN+1)) u_addsub (
      .a   (add_a),
      .b   (add_b),
      .sub (div_op),
      .sum (add_sum)
   );

   always_comb begin
      div_ge = div_shift[XLEN] | ~add_sum[XLEN];
      if (div_op) begin
         acc_n = {(div_ge ? add_sum[XLEN-1:0] : div_shift[XLEN-1:0]), acc[XLEN-2:0], div_ge};
      end else begin
         acc_n = {add_sum, acc[XLEN-1:1]};
      end
   end

   // The high product half needs the full 64-bit negation, not just a negated hi word.
   always_comb begin
      prod_s   = neg_res ? -acc : acc;
      fix_half = is_rem_op(f3) ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
      if (div_op) begin
         fix_val = neg_res ? -fix_half : fix_half;
      end else if (f3 == F3_MUL) begin
         fix_val = prod_s[XLEN-1:0];
      end else begin
         fix_val = prod_s[2*XLEN-1:XLEN];
      end
   end

   assign last_iter = (cnt == CNT_W'(XLEN-1));

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Fast-path ops go PREP -> FIX so o_done still lands two edges after acceptance.
   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE: if (i_start) state_n = ST_PREP;
         ST_PREP: state_n = fast_hit ? ST_FIX : ST_RUN;
         ST_RUN:  if (last_iter) state_n = ST_FIX;
         ST_FIX:  state_n = ST_DONE;
         ST_DONE: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
      if (i_flush) state_n = ST_IDLE;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         op_a    <= '0;
         op_b    <= '0;
         f3      <= '0;
         neg_res <= 1'b0;
         fast_q  <= 1'b0;
         acc     <= '0;
         cnt     <= '0;
         result  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_start && !i_flush) begin
                  op_a <= i_rs1_data;
                  op_b <= i_rs2_data;
                  f3   <= i_funct3;
               end
            end
            ST_PREP: begin
               op_a    <= mag_a;
               op_b    <= mag_b;
               neg_res <= prep_neg;
               fast_q  <= fast_hit;
               acc     <= '0;
               cnt     <= '0;
               if (fast_hit) result <= fast_val;
            end
            ST_RUN: begin
               acc <= acc_n;
               cnt <= cnt + CNT_W'(1);
               if (div_op) begin
                  op_a <= op_a << 1;
               end else begin
                  op_b <= op_b >> 1;
               end
            end
            ST_FIX: begin
               if (!fast_q) result <= fix_val;
            end
            default: ;
         endcase
      end
   end

   assign o_busy   = (state == ST_PREP) | (state == ST_RUN) | (state == ST_FIX);
   assign o_done   = (state == ST_DONE) & ~i_flush;
   assign o_result = result;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed testbench for muldiv_seq: vector table of RV32M ops plus flush/reset/handshake sequences.
// Build with +define+MULDIV_FAST_PATH_EN to expect the short latency on special-case ops.
module tb_muldiv_seq;
   import muldiv_pkg::*;

`ifdef MULDIV_FAST_PATH_EN
   localparam int LAT_FAST = 3;
`else
   localparam int LAT_FAST = 35;
`endif
   localparam int LAT_FULL = 35;
   localparam int NV       = 21;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      logic        special;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n, start, flush;
   logic [2:0]  funct3;
   logic [31:0] rs1, rs2;
   logic        busy, done;
   logic [31:0] result;

   int n_checks  = 0;
   int n_fail    = 0;
   int done_seen = 0;
   int exp_done  = 0;

   vec_t vecs[NV];

   always #5 clk = ~clk;

   muldiv_seq dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_start    (start),
      .i_funct3   (funct3),
      .i_rs1_data (rs1),
      .i_rs2_data (rs2),
      .i_flush    (flush),
      .o_busy     (busy),
      .o_done     (done),
      .o_result   (result)
   );

   always @(negedge clk) begin
      if (done === 1'b1) done_seen++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start  = 1'b1;
      funct3 = f;
      rs1    = a;
      rs2    = b;
   endtask

   // lat counts edges from the accepting edge (1) to the edge that opens the done cycle.
   task automatic wait_done(output logic [31:0] res, output int lat, output int busy_n);
      busy_n = 0;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat   = 1;
      while (done !== 1'b1 && lat < 100) begin
         if (busy === 1'b1) busy_n++;
         @(posedge clk);
         #1;
         lat++;
      end
      res = result;
   endtask

   task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      logic [31:0] res;
      int          lat, busy_n;
      start_op(f, a, b);
      wait_done(res, lat, busy_n);
      check({name, "_result"}, res, exp);
      check({name, "_latency"}, 32'(lat), 32'(exp_lat));
      check({name, "_busy_cycles"}, 32'(busy_n), 32'(exp_lat - 1));
      exp_done++;
      @(posedge clk);
      #1;
      check({name, "_done_pulse_width"}, {31'b0, done}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] res;
      int          lat, busy_n;

      vecs[0]  = '{F3_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
      vecs[1]  = '{F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
      vecs[2]  = '{F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0};
      vecs[3]  = '{F3_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0};
      vecs[4]  = '{F3_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0};
      vecs[5]  = '{F3_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0};
      vecs[6]  = '{F3_DIVU,   32'd100,       32'd7,         32'd14,        1'b0};
      vecs[7]  = '{F3_REMU,   32'd100,       32'd7,         32'd2,         1'b0};
      vecs[8]  = '{F3_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1};
      vecs[9]  = '{F3_REMU,   32'd5,         32'd0,         32'd5,         1'b1};
      vecs[10] = '{F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
      vecs[11] = '{F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
      vecs[12] = '{F3_MUL,    32'h0000_0000, 32'h0001_2345, 32'h0000_0000, 1'b1};
      vecs[13] = '{F3_MULH,   32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 1'b0};
      vecs[14] = '{F3_MUL,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 1'b0};
      vecs[15] = '{F3_DIV,    32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1};
      vecs[16] = '{F3_REM,    32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 1'b1};
      vecs[17] = '{F3_DIV,    32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0};
      vecs[18] = '{F3_REM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
      vecs[19] = '{F3_MULHU,  32'h8000_0000, 32'h0000_0004, 32'h0000_0002, 1'b0};
      vecs[20] = '{F3_MULHSU, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0};

      // Clock/reset
      rst_n  = 1'b0;
      start  = 1'b0;
      flush  = 1'b0;
      funct3 = '0;
      rs1    = '0;
      rs2    = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy",   {31'b0, busy}, 32'd0);
      check("reset_done",   {31'b0, done}, 32'd0);
      check("reset_result", result,        32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp,
                vecs[i].special ? LAT_FAST : LAT_FULL);
      end

      // i_start together with i_flush in IDLE is not accepted
      @(negedge clk);
      start  = 1'b1;
      flush  = 1'b1;
      funct3 = F3_MUL;
      rs1    = 32'd9;
      rs2    = 32'd9;
      @(posedge clk);
      #1;
      check("flush_idle_not_accepted", {31'b0, busy}, 32'd0);
      start = 1'b0;
      flush = 1'b0;

      // Flush in RUN cycle 10, then a fresh MUL the very next cycle
      start_op(F3_MUL, 32'd5, 32'd6);
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      check("flush_run_busy_before", {31'b0, busy}, 32'd1);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      check("flush_run_busy_after", {31'b0, busy}, 32'd0);
      check("flush_run_no_done",    {31'b0, done}, 32'd0);
      flush = 1'b0;
      run_op("flush_then_mul", F3_MUL, 32'd3, 32'd4, 32'd12, LAT_FULL);

      // Synchronous reset mid-RUN
      start_op(F3_DIVU, 32'd100, 32'd7);
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (14) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("midrun_reset_busy",   {31'b0, busy}, 32'd0);
      check("midrun_reset_done",   {31'b0, done}, 32'd0);
      check("midrun_reset_result", result,        32'd0);
      rst_n = 1'b1;
      run_op("after_reset_divu", F3_DIVU, 32'd100, 32'd7, 32'd14, LAT_FULL);

      // i_start held through the DONE cycle is ignored, then accepted in IDLE
      start_op(F3_MUL, 32'd6, 32'd7);
      wait_done(res, lat, busy_n);
      check("hold_first_result", res, 32'd42);
      exp_done++;
      start  = 1'b1;
      funct3 = F3_DIVU;
      rs1    = 32'd100;
      rs2    = 32'd7;
      @(posedge clk);
      #1;
      check("hold_done_not_accepted", {31'b0, busy}, 32'd0);
      wait_done(res, lat, busy_n);
      check("hold_reissue_result",  res,        32'd14);
      check("hold_reissue_latency", 32'(lat),   32'(LAT_FULL));
      exp_done++;
      @(posedge clk);
      #1;

      // i_start while busy must not re-latch operands
      start_op(F3_REMU, 32'd100, 32'd7);
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      start  = 1'b1;
      funct3 = F3_MUL;
      rs1    = 32'd3;
      rs2    = 32'd3;
      wait_done(res, lat, busy_n);
      check("busy_start_ignored_result", res, 32'd2);
      exp_done++;
      @(posedge clk);
      #1;

      // Flush raised during the DONE cycle suppresses o_done
      start_op(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (34) @(posedge clk);
      #1;
      flush = 1'b1;
      #1;
      check("flush_done_suppressed", {31'b0, done}, 32'd0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush_done_idle_after", {31'b0, busy}, 32'd0);

      repeat (3) @(posedge clk);
      #1;
      check("done_pulse_count", 32'(done_seen), 32'(exp_done));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
